// File: rtl/ch_history.sv
// ch_history: per-channel sample history with a shared circular write pointer,
// running signed sums of the held samples and a registered random tap read port.
//
// Handshake: a frame on in_data transfers on any rising edge where in_valid and
// in_ready are both high. in_ready is low only while flush is asserted, so a
// frame offered during flush is dropped and not held over. The read port is
// fire-and-forget: each rd_req cycle yields exactly one rd_valid pulse on the
// following cycle, and no back-pressure applies.
module ch_history #(
  parameter int DATA_W   = 10,
  parameter int DEPTH    = 20,
  parameter int CHANNELS = 2,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SUM_W   = DATA_W + $clog2(DEPTH)
) (
  input  logic                       clk_clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic                       rd_req,
  input  logic [CH_W-1:0]            rd_ch,
  input  logic [PTR_W-1:0]           rd_tap,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_err,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic [CHANNELS*SUM_W-1:0]  sum_out
);

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_LOC = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_M1  = (PTR_W+1)'(DEPTH - 1);
  localparam logic [CH_W:0]    CH_LIMIT  = (CH_W+1)'(CHANNELS);

  logic [PTR_W-1:0]         wp_q, wp_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [SUM_W-1:0]  sum_q [CHANNELS];
  logic signed [SUM_W-1:0]  sum_d [CHANNELS];
  logic [DATA_W-1:0]        mem_q [CHANNELS][DEPTH];

  logic                     rd_valid_q, rd_valid_d;
  logic                     rd_err_q, rd_err_d;
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;

  logic                     accept;
  logic                     full_w;

  // Read address path
  logic [CNT_W-1:0]         tap_ext;
  logic                     tap_bad;
  logic                     ch_bad;
  logic [PTR_W:0]           loc_raw;
  logic [PTR_W-1:0]         rd_loc;
  logic [CH_W-1:0]          ch_sel;
  logic [DATA_W-1:0]        rd_sample;

  function automatic logic signed [SUM_W-1:0] sext(input logic [DATA_W-1:0] x);
    return SUM_W'($signed(x));
  endfunction

  assign in_ready = ~flush;
  assign accept   = in_valid & ~flush;
  assign full_w   = (count_q == DEPTH_CNT);

  // Next pointer, fill count and running sums; flush wins over an offered frame
  always_comb begin
    wp_d    = wp_q;
    count_d = count_q;
    for (int c = 0; c < CHANNELS; c++) sum_d[c] = sum_q[c];
    if (flush) begin
      wp_d    = '0;
      count_d = '0;
      for (int c = 0; c < CHANNELS; c++) sum_d[c] = '0;
    end else if (accept) begin
      wp_d = (wp_q == LAST_PTR) ? '0 : wp_q + PTR_W'(1);
      if (!full_w) count_d = count_q + CNT_W'(1);
      // When full, the slot at wp holds the oldest sample, which leaves the window
      for (int c = 0; c < CHANNELS; c++) begin
        sum_d[c] = sum_q[c] + sext(in_data[c*DATA_W +: DATA_W])
                 - (full_w ? sext(mem_q[c][wp_q]) : SUM_W'(0));
      end
    end
  end

  // Pointer, count and sum registers
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q    <= '0;
      count_q <= '0;
      for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
    end else begin
      wp_q    <= wp_d;
      count_q <= count_d;
      for (int c = 0; c < CHANNELS; c++) sum_q[c] <= sum_d[c];
    end
  end

  // Sample storage; never cleared, stale entries are masked by the fill count
  always_ff @(posedge clk_clk) begin
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) mem_q[c][wp_q] <= in_data[c*DATA_W +: DATA_W];
    end
  end

  // Tap t maps to (wp-1-t) mod DEPTH using the pre-write pointer and storage
  always_comb begin
    tap_ext = CNT_W'(rd_tap);
    tap_bad = (tap_ext >= count_q) || (tap_ext >= DEPTH_CNT);
    ch_bad  = ({1'b0, rd_ch} >= CH_LIMIT);
    loc_raw = {1'b0, wp_q} + DEPTH_M1 - {1'b0, rd_tap};
    if (loc_raw >= DEPTH_LOC) loc_raw = loc_raw - DEPTH_LOC;
    rd_loc    = loc_raw[PTR_W-1:0];
    ch_sel    = ch_bad ? '0 : rd_ch;
    rd_sample = mem_q[ch_sel][rd_loc];
  end

  // Read result next-state: data only on a legal tap, zeros otherwise
  always_comb begin
    rd_valid_d = rd_req;
    rd_err_d   = 1'b0;
    rd_data_d  = '0;
    if (rd_req) begin
      if (tap_bad || ch_bad) begin
        rd_err_d = 1'b1;
      end else begin
        rd_data_d = rd_sample;
      end
    end
  end

  // Read result registers; reset drops any read in flight
  always_ff @(posedge clk_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign full     = full_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_sum
    assign sum_out[g*SUM_W +: SUM_W] = sum_q[g];
  end

endmodule
